// File: rtl/regfile_write_bank_if.sv
// Bus between the register-file write bank and its neighbours: write request
// inputs, the 32 register outputs feeding the read mux, and the pending-write
// view used by read-side bypass logic.
interface regfile_write_bank_if #(
  parameter int WIDTH = 32
);

  logic             we;
  logic [4:0]       wa;
  logic [WIDTH-1:0] wd;
  logic             clr;

  logic [WIDTH-1:0] R [32];
  logic             pend_vld;
  logic [4:0]       pend_addr;
  logic [WIDTH-1:0] pend_data;
  logic             wr_ack;

  // Requester / read side drives writes and observes registers and the pending entry
  modport master (
    output we, wa, wd, clr,
    input  R, pend_vld, pend_addr, pend_data, wr_ack
  );

  // The write bank itself
  modport slave (
    input  we, wa, wd, clr,
    output R, pend_vld, pend_addr, pend_data, wr_ack
  );

endinterface

// File: rtl/regfile_write_bank.sv
// Write side of the 32 x WIDTH general register file.
// A write request is captured into a one-entry write stage on one edge and
// committed into the addressed register on the next edge. The stage contents
// are exported so read-side logic can bypass the uncommitted value.
// With ZERO_R0 set, register 0 never accepts a commit and therefore reads 0.
module regfile_write_bank #(
  parameter int WIDTH   = 32,
  parameter int ZERO_R0 = 1
) (
  input logic            clk,
  input logic            reset_n,
  regfile_write_bank_if.slave bus
);

  // Commit mask: bit 0 is cleared when R0 is hardwired so its register stays at 0
  localparam logic [31:0] WRITE_MASK = (ZERO_R0 != 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;

  logic             r_pendVld;
  logic [4:0]       r_pendAddr;
  logic [WIDTH-1:0] r_pendData;
  logic             r_wrAck;

  logic [31:0]      w_oneHot;
  logic [31:0]      w_wrEn;

  // Write stage: capture a request every cycle; clear drops both the held entry and the new request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pendVld  <= 1'b0;
      r_pendAddr <= '0;
      r_pendData <= '0;
    end else if (bus.clr) begin
      r_pendVld  <= 1'b0;
    end else begin
      r_pendVld <= bus.we;
      if (bus.we) begin
        r_pendAddr <= bus.wa;
        r_pendData <= bus.wd;
      end
    end
  end

  // Acknowledge pulse for the cycle following a commit; a clear discards the entry silently
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrAck <= 1'b0;
    end else begin
      r_wrAck <= r_pendVld & ~bus.clr;
    end
  end

  // 5:32 one-hot decode of the pending address, gated by a valid entry and the R0 mask
  always_comb begin
    w_oneHot = 32'd1 << r_pendAddr;
    w_wrEn   = '0;
    if (r_pendVld && !bus.clr) begin
      w_wrEn = w_oneHot & WRITE_MASK;
    end
  end

  // One register per address; each loads only when its decode bit is set
  for (genvar gi = 0; gi < 32; gi++) begin : g_reg
    logic [WIDTH-1:0] r_value;

    // Register storage with synchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_value <= '0;
      end else if (bus.clr) begin
        r_value <= '0;
      end else if (w_wrEn[gi]) begin
        r_value <= r_pendData;
      end
    end

    assign bus.R[gi] = r_value;
  end

  assign bus.pend_vld  = r_pendVld;
  assign bus.pend_addr = r_pendAddr;
  assign bus.pend_data = r_pendData;
  assign bus.wr_ack    = r_wrAck;

endmodule

// File: tb/tb_regfile_write_bank.sv
// Self-checking bench for regfile_write_bank. Two instances (R0 hardwired and
// R0 ordinary) see identical stimulus and are compared every cycle against a
// request-queue model of the register file.
module tb_regfile_write_bank;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  regfile_write_bank_if #(.WIDTH(32)) bus1 ();
  regfile_write_bank_if #(.WIDTH(32)) bus0 ();

  regfile_write_bank #(.WIDTH(32), .ZERO_R0(1)) dutZero (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1.slave)
  );

  regfile_write_bank #(.WIDTH(32), .ZERO_R0(0)) dutPlain (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  int errors = 0;
  int checks = 0;

  wr_t         pendQ [$];
  logic [31:0] mRegs1 [32];
  logic [31:0] mRegs0 [32];
  logic        mAck;
  logic [4:0]  mLastAddr;
  logic [31:0] mLastData;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    pendQ.delete();
    for (int i = 0; i < 32; i++) begin
      mRegs1[i] = '0;
      mRegs0[i] = '0;
    end
    mAck      = 1'b0;
    mLastAddr = '0;
    mLastData = '0;
  endtask

  task automatic modelEdge(input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic clr);
    wr_t e;
    if (clr) begin
      pendQ.delete();
      for (int i = 0; i < 32; i++) begin
        mRegs1[i] = '0;
        mRegs0[i] = '0;
      end
      mAck = 1'b0;
    end else begin
      mAck = (pendQ.size() != 0);
      if (pendQ.size() != 0) begin
        e = pendQ.pop_front();
        mRegs0[e.addr] = e.data;
        if (e.addr != 5'd0) mRegs1[e.addr] = e.data;
      end
      if (we) begin
        e.addr = wa;
        e.data = wd;
        pendQ.push_back(e);
        mLastAddr = wa;
        mLastData = wd;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic expVld;
    expVld = (pendQ.size() != 0);
    check($sformatf("%s z1.pend_vld", tag), 32'(bus1.pend_vld), 32'(expVld));
    check($sformatf("%s z0.pend_vld", tag), 32'(bus0.pend_vld), 32'(expVld));
    check($sformatf("%s z1.pend_addr", tag), 32'(bus1.pend_addr), 32'(mLastAddr));
    check($sformatf("%s z0.pend_addr", tag), 32'(bus0.pend_addr), 32'(mLastAddr));
    check($sformatf("%s z1.pend_data", tag), bus1.pend_data, mLastData);
    check($sformatf("%s z0.pend_data", tag), bus0.pend_data, mLastData);
    check($sformatf("%s z1.wr_ack", tag), 32'(bus1.wr_ack), 32'(mAck));
    check($sformatf("%s z0.wr_ack", tag), 32'(bus0.wr_ack), 32'(mAck));
    for (int i = 0; i < 32; i++) begin
      check($sformatf("%s z1.R%0d", tag, i), bus1.R[i], mRegs1[i]);
      check($sformatf("%s z0.R%0d", tag, i), bus0.R[i], mRegs0[i]);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic clr, input string tag);
    bus1.we = we; bus1.wa = wa; bus1.wd = wd; bus1.clr = clr;
    bus0.we = we; bus0.wa = wa; bus0.wd = wd; bus0.clr = clr;
    @(posedge clk);
    modelEdge(we, wa, wd, clr);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    bus1.we = 1'b0; bus1.wa = '0; bus1.wd = '0; bus1.clr = 1'b0;
    bus0.we = 1'b0; bus0.wa = '0; bus0.wd = '0; bus0.clr = 1'b0;
    modelReset();

    $display("[TB] reset state");
    #3;
    checkOutput("reset");
    #9 reset_n = 1'b1;

    $display("[TB] single write to R5");
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, "w5.capture");
    check("w5.capture.pend_addr", 32'(bus1.pend_addr), 32'd5);
    check("w5.capture.R5_not_yet", bus1.R[5], 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, "w5.commit");
    check("w5.commit.R5", bus1.R[5], 32'hDEAD_BEEF);
    check("w5.commit.ack", 32'(bus1.wr_ack), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, "w5.idle");

    $display("[TB] back-to-back writes");
    applyStimulus(1'b1, 5'd7, 32'hA, 1'b0, "b2b.1");
    applyStimulus(1'b1, 5'd7, 32'hB, 1'b0, "b2b.2");
    applyStimulus(1'b1, 5'd8, 32'hC, 1'b0, "b2b.3");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, "b2b.4");
    check("b2b.R7", bus0.R[7], 32'hB);
    check("b2b.R8", bus0.R[8], 32'hC);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, "b2b.5");

    $display("[TB] write to R0");
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, "r0.capture");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, "r0.commit");
    check("r0.z1.R0", bus1.R[0], 32'h0);
    check("r0.z0.R0", bus0.R[0], 32'hFFFF_FFFF);
    check("r0.z1.ack", 32'(bus1.wr_ack), 32'd1);

    $display("[TB] clear overrides pending write and new request");
    applyStimulus(1'b1, 5'd9, 32'h55, 1'b0, "clr.capture");
    applyStimulus(1'b1, 5'd10, 32'h1234, 1'b1, "clr.edge");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, "clr.after");
    check("clr.R9", bus0.R[9], 32'h0);
    check("clr.R10", bus0.R[10], 32'h0);

    $display("[TB] address sweep");
    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b1, 5'(a), 32'(a + 1), 1'b0, $sformatf("sweep.%0d", a));
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, "sweep.drain");
    for (int n = 1; n < 32; n++) begin
      check($sformatf("sweep.z1.R%0d", n), bus1.R[n], 32'(n + 1));
    end
    check("sweep.z1.R0", bus1.R[0], 32'h0);
    check("sweep.z0.R0", bus0.R[0], 32'h1);

    $display("[TB] asynchronous reset with pending write");
    applyStimulus(1'b1, 5'd12, 32'h77, 1'b0, "arst.pending");
    applyStimulus(1'b1, 5'd13, 32'h88, 1'b0, "arst.pending2");
    #2 reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("arst.asserted");
    bus1.we = 1'b0; bus0.we = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("arst.held");
    #2 reset_n = 1'b1;
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b0, "arst.w3.capture");
    check("arst.w3.R3_not_yet", bus1.R[3], 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, "arst.w3.commit");
    check("arst.w3.R3", bus1.R[3], 32'h11);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 5'($urandom), 32'($urandom),
                    1'($urandom_range(0, 15) == 0), $sformatf("rand.%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
